instr_memory: RTL and testbench

Loadable instruction memory for the Harvard MIPS CPU: the responder on the CPU's instruction-fetch port. A loader streams the program in over a valid/ready handshake, and the block then serves combinational fetches at the reset vector `0xBFC00000`. It holds the CPU off with `cpu_hold` until an image is loaded, returns NOP for out-of-image fetches, and flags bad fetch addresses. It replaces the hand-written fetch decode in the CPU benches.

---
 rtl/mips_mem_pkg.sv | 12 +
 rtl/instr_memory_ram.sv | 24 ++
 rtl/instr_memory.sv | 122 ++++++++++++
 tb/tb_instr_memory.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and state type for the MIPS instruction/data memory models.
package mips_mem_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] NOP          = 32'h00000000;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } imem_state_t;

endpackage

// File: rtl/instr_memory_ram.sv
// Word-wide RAM: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the owner masks words it has not written.
module instr_ram #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [31:0]                    i_wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_memory.sv
// Loadable instruction memory: streams an image in over valid/ready, then
// serves zero-latency fetches relative to BASE_ADDR until reloaded.
module instr_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        loaded,
    output logic        cpu_hold,
    output logic        overflow,
    output logic        fault,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned LW = AW + 1;

    imem_state_t r_state;
    imem_state_t w_next_state;

    // Write pointer and image length always advance together, so one counter serves both.
    logic [LW-1:0] r_length;
    logic          r_overflow;
    logic          r_fault;

    logic          w_xfer;
    logic          w_we;
    logic          w_last_slot;
    logic [31:0]   w_offset;
    logic [29:0]   w_index;
    logic          w_legal;
    logic [31:0]   w_rdata;

    assign load_ready  = (r_state == LOAD) && !reset;
    assign w_xfer      = load_valid && load_ready;
    assign w_we        = w_xfer && !load_start;
    assign w_last_slot = (r_length == LW'(DEPTH_WORDS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; load_start overrides everything
    always_comb begin
        w_next_state = r_state;
        if (load_start) begin
            w_next_state = LOAD;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_xfer && (load_last || w_last_slot)) begin
                        w_next_state = READY;
                    end
                end
                READY:   w_next_state = READY;
                default: w_next_state = LOAD;
            endcase
        end
    end

    // Image length, truncation flag and fetch-fault flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_length   <= '0;
            r_overflow <= 1'b0;
            r_fault    <= 1'b0;
        end else if (load_start) begin
            r_length   <= '0;
            r_overflow <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (w_we) begin
                r_length <= r_length + LW'(1);
                if (w_last_slot && !load_last) begin
                    r_overflow <= 1'b1;
                end
            end
            if ((r_state == READY) && !w_legal) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Fetch decode: wraparound offset, word aligned, inside the loaded image
    assign w_offset = instr_address - BASE_ADDR;
    assign w_index  = w_offset[31:2];
    assign w_legal  = (instr_address >= BASE_ADDR)
                   && (w_offset[1:0] == 2'b00)
                   && (w_index < 30'(r_length));

    instr_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_length[AW-1:0]),
        .i_wdata (load_data),
        .i_raddr (w_index[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign loaded         = (r_state == READY);
    assign cpu_hold       = !loaded;
    assign overflow       = r_overflow;
    assign fault          = r_fault;
    assign instr_readdata = (loaded && w_legal) ? w_rdata : NOP;

endmodule

// File: tb/tb_instr_memory.sv
// Self-checking bench for instr_memory against a flat-array reference model.
module tb_instr_memory;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load_start, load_valid, load_last;
    logic [31:0] load_data, instr_address;
    logic        load_ready, loaded, cpu_hold, overflow, fault;
    logic [31:0] instr_readdata;

    logic        ls4, lv4, ll4;
    logic [31:0] ld4, a4;
    logic        lr4, loaded4, hold4, ov4, fault4;
    logic [31:0] rd4;

    instr_memory #(.DEPTH_WORDS(256), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .loaded(loaded), .cpu_hold(cpu_hold), .overflow(overflow), .fault(fault),
        .instr_address(instr_address), .instr_readdata(instr_readdata)
    );

    instr_memory #(.DEPTH_WORDS(4), .BASE_ADDR(BASE)) u_dut4 (
        .clk(clk), .reset(reset), .load_start(ls4), .load_valid(lv4),
        .load_ready(lr4), .load_data(ld4), .load_last(ll4),
        .loaded(loaded4), .cpu_hold(hold4), .overflow(ov4), .fault(fault4),
        .instr_address(a4), .instr_readdata(rd4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the loaded image as a plain array plus its length
    logic [31:0] ref_img [256];
    int          ref_len;
    bit          ref_loaded;
    bit          ref_fault;
    logic [31:0] prog [256];

    function automatic bit is_legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && (off % 4 == 0) && ((off / 4) < ref_len);
    endfunction

    function automatic logic [31:0] exp_fetch(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!ref_loaded || !is_legal(a)) return 32'h0;
        return ref_img[off / 4];
    endfunction

    task automatic set_demo_prog();
        prog[0] = 32'h24010020; prog[1] = 32'h10200003; prog[2] = 32'h24020020;
        prog[3] = 32'h10220002; prog[4] = 32'h24420020;
    endtask

    task automatic do_load(input int n, input int max_gap, input bit do_start);
        @(negedge clk);
        if (do_start) begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
        end
        ref_loaded = 1'b0;
        ref_fault  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 1)) @(negedge clk);
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == n - 1);
            @(negedge clk);
            load_valid = 1'b0;
            load_last  = 1'b0;
            load_data  = $urandom;
        end
        for (int i = 0; i < n; i++) ref_img[i] = prog[i];
        ref_len    = n;
        ref_loaded = 1'b1;
    endtask

    task automatic fetch_check(input logic [31:0] a);
        logic [31:0] exp;
        @(negedge clk);
        instr_address = a;
        #1;
        exp = exp_fetch(a);
        n_vec++;
        if (instr_readdata !== exp) begin
            n_err++;
            $display("FAIL fetch addr=%h got=%h want=%h", a, instr_readdata, exp);
        end
        @(posedge clk);
        if (ref_loaded && !is_legal(a)) ref_fault = 1'b1;
        #1;
        instr_address = BASE;
        n_vec++;
        if (fault !== ref_fault) begin
            n_err++;
            $display("FAIL fault_after addr=%h got=%b want=%b", a, fault, ref_fault);
        end
    endtask

    task automatic check_status(input string nm, input logic exp_loaded);
        n_vec++;
        if (loaded !== exp_loaded || cpu_hold !== !exp_loaded) begin
            n_err++;
            $display("FAIL %s loaded/cpu_hold got=%b/%b want=%b/%b", nm, loaded, cpu_hold,
                     exp_loaded, !exp_loaded);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_vec++;
        if (loaded !== 1'b0 || cpu_hold !== 1'b1 || overflow !== 1'b0 || fault !== 1'b0 ||
            load_ready !== 1'b0 || instr_readdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values got loaded=%b hold=%b ovf=%b fault=%b ready=%b rd=%h want 0/1/0/0/0/0",
                     loaded, cpu_hold, overflow, fault, load_ready, instr_readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset got=%b want=1", load_ready);
        end
    endtask

    task automatic test_basic_load();
        set_demo_prog();
        do_load(5, 0, 1'b1);
        check_status("basic_loaded", 1'b1);
        fetch_check(BASE);
        fetch_check(BASE + 32'h10);
        fetch_check(BASE + 32'h14);
    endtask

    task automatic test_backpressure();
        set_demo_prog();
        do_load(5, 3, 1'b1);
        check_status("bp_loaded", 1'b1);
        for (int i = 0; i < 6; i++) fetch_check(BASE + 32'(4 * i));
    endtask

    task automatic test_overflow();
        logic [31:0] w [6];
        int acc;
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        @(negedge clk);
        ls4 = 1'b1;
        @(negedge clk);
        ls4 = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            lv4 = 1'b1; ld4 = w[i]; ll4 = 1'b0;
            #1;
            if (i == 4) begin
                n_vec++;
                if (lr4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_ready_drop got=%b want=0", lr4);
                end
            end
            if (lr4) acc++;
            @(negedge clk);
        end
        lv4 = 1'b0;
        n_vec++;
        if (acc !== 4) begin
            n_err++;
            $display("FAIL ovf_accepted got=%0d want=4", acc);
        end
        n_vec++;
        if (ov4 !== 1'b1 || loaded4 !== 1'b1 || hold4 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_flags got ovf=%b loaded=%b hold=%b want 1/1/0", ov4, loaded4, hold4);
        end
        for (int i = 0; i < 5; i++) begin
            a4 = BASE + 32'(4 * i);
            #1;
            n_vec++;
            if (rd4 !== ((i < 4) ? w[i] : 32'h0)) begin
                n_err++;
                $display("FAIL ovf_fetch idx=%0d got=%h want=%h", i, rd4, (i < 4) ? w[i] : 32'h0);
            end
        end
        a4 = BASE;
    endtask

    task automatic test_misaligned();
        set_demo_prog();
        do_load(5, 0, 1'b1);
        n_vec++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_pre_fault got=%b want=0", fault);
        end
        fetch_check(BASE + 32'h2);
        fetch_check(32'h0000_0000);
    endtask

    task automatic test_reset_midload();
        prog[0] = $urandom; prog[1] = $urandom;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        ref_loaded = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = prog[i]; load_last = 1'b0;
            @(negedge clk);
        end
        load_valid = 1'b0;
        #2;
        reset = 1'b1;
        instr_address = BASE;
        #1;
        ref_fault = 1'b0;
        check_status("midload_reset", 1'b0);
        n_vec++;
        if (instr_readdata !== 32'h0) begin
            n_err++;
            $display("FAIL midload_fetch got=%h want=00000000", instr_readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        set_demo_prog();
        do_load(5, 0, 1'b0);
        check_status("reload_loaded", 1'b1);
        for (int i = 0; i < 6; i++) fetch_check(BASE + 32'(4 * i));
    endtask

    task automatic test_start_priority();
        set_demo_prog();
        do_load(5, 0, 1'b1);
        fetch_check(BASE + 32'h14);
        @(negedge clk);
        load_start = 1'b1; load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b0;
        @(posedge clk);
        #1;
        load_start = 1'b0; load_valid = 1'b0;
        ref_loaded = 1'b0; ref_fault = 1'b0;
        n_vec++;
        if (fault !== 1'b0 || loaded !== 1'b0 || cpu_hold !== 1'b1 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_priority got fault=%b loaded=%b hold=%b ready=%b want 0/0/1/1",
                     fault, loaded, cpu_hold, load_ready);
        end
        prog[0] = 32'h11111111; prog[1] = 32'h22222222;
        do_load(2, 0, 1'b0);
        for (int i = 0; i < 3; i++) fetch_check(BASE + 32'(4 * i));
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(20, 1);
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            do_load(n, $urandom_range(2, 0), 1'b1);
            check_status("rand_loaded", 1'b1);
            for (int k = 0; k < 15; k++) begin
                logic [31:0] a;
                case ($urandom_range(3, 0))
                    0: a = BASE + 32'(4 * $urandom_range(n - 1, 0));
                    1: a = BASE + 32'(4 * $urandom_range(n + 8, n));
                    2: a = BASE + 32'(4 * $urandom_range(n, 0)) + 32'($urandom_range(3, 1));
                    default: a = $urandom;
                endcase
                fetch_check(a);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout n_vec=%0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        load_start = 0; load_valid = 0; load_last = 0; load_data = 0; instr_address = BASE;
        ls4 = 0; lv4 = 0; ll4 = 0; ld4 = 0; a4 = BASE;
        ref_len = 0; ref_loaded = 0; ref_fault = 0;
        test_reset();
        test_basic_load();
        test_backpressure();
        test_overflow();
        test_misaligned();
        test_reset_midload();
        test_start_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
